mmio_word_fifo: RTL and testbench

MMIO_WORD_FIFO -- requirements
Module: mmio_word_fifo

---
 rtl/mmio_fifo_pkg.sv | 13 +
 rtl/mmio_fifo_mem.sv | 19 +
 rtl/mmio_word_fifo.sv | 92 +++++++++
 tb/tb_mmio_word_fifo.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mmio_fifo_pkg.sv
// mmio_fifo_pkg: shared FIFO defaults and the status word the AFU exposes over MMIO
package mmio_fifo_pkg;
    localparam int DATA_W_DEF = 64;
    localparam int DEPTH_DEF  = 8;
    localparam int CNT_W_DEF  = $clog2(DEPTH_DEF) + 1;
    typedef struct packed {
        logic                 full;
        logic                 empty;
        logic                 overflow;
        logic                 underflow;
        logic [CNT_W_DEF-1:0] count;
    } fifo_status_t;
endpackage

// File: rtl/mmio_fifo_mem.sv
// mmio_fifo_mem: unreset storage array, one write port and one asynchronous read port
module mmio_fifo_mem #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    // write the accepted push word on the rising edge
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/mmio_word_fifo.sv
// mmio_word_fifo: MMIO word FIFO with registered pop data, peek and sticky error flags
module mmio_word_fifo
    import mmio_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [DATA_W-1:0]      push_data,
    input  logic                   pop,
    input  logic                   flush,
    input  logic                   clr_err,
    output logic [DATA_W-1:0]      pop_data,
    output logic                   pop_valid,
    output logic [DATA_W-1:0]      peek_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow,
    output fifo_status_t           status
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] pop_data_q, pop_data_d, rd_data;
    logic              pop_valid_q, pop_valid_d;
    logic              overflow_q, overflow_d, underflow_q, underflow_d;
    logic              do_push, do_pop, ovf_evt, udf_evt;

    assign full    = count_q == CNT_W'(DEPTH);
    assign empty   = count_q == '0;
    // a pop frees the slot a full-FIFO push needs; an empty FIFO never bypasses
    assign do_push = push & ~flush & (~full | pop);
    assign do_pop  = pop & ~flush & ~empty;
    assign ovf_evt = push & ~flush & full & ~pop;
    assign udf_evt = pop & ~flush & empty;

    mmio_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (do_push),
        .waddr (wr_ptr_q),
        .wdata (push_data),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    // next state: flush beats push/pop, new error events beat clr_err
    always_comb begin
        wr_ptr_d    = flush ? '0 : wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d    = flush ? '0 : rd_ptr_q + PTR_W'(do_pop);
        count_d     = flush ? '0 : count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        pop_data_d  = do_pop ? rd_data : pop_data_q;
        pop_valid_d = do_pop;
        overflow_d  = ovf_evt | (overflow_q & ~clr_err);
        underflow_d = udf_evt | (underflow_q & ~clr_err);
    end

    // state registers, cleared asynchronously by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign pop_data  = pop_data_q;
    assign pop_valid = pop_valid_q;
    assign peek_data = empty ? '0 : rd_data;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign status    = '{full: full, empty: empty, overflow: overflow_q,
                         underflow: underflow_q, count: CNT_W_DEF'(count_q)};
endmodule

// File: tb/tb_mmio_word_fifo.sv
// tb_mmio_word_fifo: directed stimulus checked against a queue model plus literal expectations
module tb_mmio_word_fifo;
    import mmio_fifo_pkg::*;
    localparam int DEPTH = 8;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        push = 1'b0, pop = 1'b0, flush = 1'b0, clr_err = 1'b0;
    logic [63:0] push_data = '0;
    logic [63:0] pop_data, peek_data;
    logic        pop_valid, full, empty, overflow, underflow;
    logic [3:0]  count;
    fifo_status_t status;

    mmio_word_fifo dut (
        .clk(clk), .rst_n(rst_n), .push(push), .push_data(push_data), .pop(pop),
        .flush(flush), .clr_err(clr_err), .pop_data(pop_data), .pop_valid(pop_valid),
        .peek_data(peek_data), .full(full), .empty(empty), .count(count),
        .overflow(overflow), .underflow(underflow), .status(status)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    logic [63:0] m_q[$];
    logic [63:0] m_pd = '0;
    logic        m_pv = 0, m_ovf = 0, m_udf = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pd = '0; m_pv = 0; m_ovf = 0; m_udf = 0;
    endtask

    task automatic model(input logic pu, input logic [63:0] d, input logic po,
                         input logic fl, input logic ce);
        int n;
        n = m_q.size();
        m_pv = 0;
        m_ovf = m_ovf & ~ce;
        m_udf = m_udf & ~ce;
        if (fl) m_q.delete();
        else begin
            if (pu && n == DEPTH && !po) m_ovf = 1;
            if (po && n == 0) m_udf = 1;
            if (po && n > 0) begin m_pd = m_q.pop_front(); m_pv = 1; end
            if (pu && (n < DEPTH || po)) m_q.push_back(d);
        end
    endtask

    task automatic step(input logic pu, input logic [63:0] d, input logic po,
                        input logic fl = 0, input logic ce = 0);
        push = pu; push_data = d; pop = po; flush = fl; clr_err = ce;
        @(posedge clk);
        model(pu, d, po, fl, ce);
        @(negedge clk);
        push = 0; pop = 0; flush = 0; clr_err = 0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("count", 64'(count), 64'(m_q.size()));
            chk("full", 64'(full), 64'(m_q.size() == DEPTH));
            chk("empty", 64'(empty), 64'(m_q.size() == 0));
            chk("pop_valid", 64'(pop_valid), 64'(m_pv));
            chk("pop_data", pop_data, m_pd);
            chk("peek_data", peek_data, m_q.size() > 0 ? m_q[0] : 64'h0);
            chk("overflow", 64'(overflow), 64'(m_ovf));
            chk("underflow", 64'(underflow), 64'(m_udf));
            chk("status", 64'(status), 64'({m_q.size() == DEPTH, m_q.size() == 0, m_ovf, m_udf, 4'(m_q.size())}));
        end
    end

    initial begin
        #12;
        chk("rst_empty", 64'(empty), 64'h1);
        chk("rst_full", 64'(full), 64'h0);
        chk("rst_count", 64'(count), 64'h0);
        @(negedge clk) rst_n = 1;
        // pop straight after reset
        step(0, 0, 1);
        chk("r_udf", 64'(underflow), 64'h1);
        chk("r_pv", 64'(pop_valid), 64'h0);
        chk("r_pd", pop_data, 64'h0);
        chk("r_empty", 64'(empty), 64'h1);
        step(0, 0, 0, 0, 1);
        // fill, then overflow
        for (int i = 0; i < 8; i++) step(1, 64'h11 + 64'(i), 0);
        step(1, 64'h99, 0);
        chk("f_full", 64'(full), 64'h1);
        chk("f_count", 64'(count), 64'h8);
        chk("f_ovf", 64'(overflow), 64'h1);
        chk("f_peek", peek_data, 64'h11);
        step(0, 0, 0, 0, 1);
        chk("f_clr", 64'(overflow), 64'h0);
        // push and pop together while full
        step(1, 64'hAA, 1);
        chk("fp_pd", pop_data, 64'h11);
        chk("fp_count", 64'(count), 64'h8);
        chk("fp_ovf", 64'(overflow), 64'h0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1);
            chk("drain", pop_data, i == 7 ? 64'hAA : 64'h12 + 64'(i));
        end
        // pointer wrap
        for (int i = 0; i < 12; i++) begin
            step(1, 64'h100 + 64'(i), 0);
            chk("w_peek", peek_data, 64'h100 + 64'(i));
            step(0, 0, 1);
            chk("w_pd", pop_data, 64'h100 + 64'(i));
        end
        // flush beats push and pop, flags unchanged
        step(0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 64'h21 + 64'(i), 0);
        step(1, 64'h55, 1, 1);
        chk("fl_count", 64'(count), 64'h0);
        chk("fl_empty", 64'(empty), 64'h1);
        chk("fl_pv", 64'(pop_valid), 64'h0);
        chk("fl_udf", 64'(underflow), 64'h1);
        chk("fl_ovf", 64'(overflow), 64'h0);
        chk("fl_peek", peek_data, 64'h0);
        // error event beats clr_err
        for (int i = 0; i < 8; i++) step(1, 64'h31 + 64'(i), 0);
        step(1, 64'h41, 0);
        step(1, 64'h42, 0, 0, 1);
        chk("ce_ovf_hold", 64'(overflow), 64'h1);
        chk("ce_udf_clr", 64'(underflow), 64'h0);
        step(0, 0, 0, 0, 1);
        chk("ce_ovf_clr", 64'(overflow), 64'h0);
        chk("ce_peek", peek_data, 64'h31);
        // asynchronous reset mid-operation
        step(0, 0, 1);
        #2 rst_n = 0;
        model_reset();
        #1;
        chk("ar_count", 64'(count), 64'h0);
        chk("ar_empty", 64'(empty), 64'h1);
        chk("ar_pd", pop_data, 64'h0);
        @(negedge clk) rst_n = 1;
        step(0, 0, 1);
        chk("ar_udf", 64'(underflow), 64'h1);
        chk("ar_pv", 64'(pop_valid), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
